// File: rtl/unified_cache_mem_bridge.sv
// Cache-to-memory bridge: queues miss-fill / writeback packets in a small FIFO and serialises
// them onto a request/ready memory port, one transaction at a time, returning read fills.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 66
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 0
`endif
`ifndef UNIFIED_CACHE_PACKET_IS_WRITE_POS
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS 1
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_LO
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO 2
`endif
`ifndef UNIFIED_CACHE_PACKET_DATA_POS_LO
`define UNIFIED_CACHE_PACKET_DATA_POS_LO 34
`endif
`ifndef CPU_ADDR_LEN_IN_BITS
`define CPU_ADDR_LEN_IN_BITS 32
`endif

module unified_cache_mem_bridge #(
  parameter int unsigned UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int unsigned QUEUE_SIZE                         = 4,
  parameter int unsigned DATA_WIDTH                         = 32,
  parameter int unsigned PACKET_WRITE_POS                   = `UNIFIED_CACHE_PACKET_IS_WRITE_POS,
  parameter int unsigned PACKET_DATA_POS_LO                 = `UNIFIED_CACHE_PACKET_DATA_POS_LO
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] to_mem_packet_in,
  output logic                                          to_mem_packet_ack_out,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] from_mem_packet_out,
  input  logic                                          from_mem_packet_ack_in,
  output logic                                          mem_req_out,
  input  logic                                          mem_ready_in,
  output logic                                          mem_we_out,
  output logic [`CPU_ADDR_LEN_IN_BITS-1:0]              mem_addr_out,
  output logic [DATA_WIDTH-1:0]                         mem_wdata_out,
  input  logic                                          mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0]                         mem_rdata_in
);

  localparam int unsigned PacketWidth = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int unsigned AddrWidth   = `CPU_ADDR_LEN_IN_BITS;
  localparam int unsigned AddrPosLo   = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
  localparam int unsigned ValidPos    = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int unsigned IdxWidth    = $clog2(QUEUE_SIZE);
  localparam logic [IdxWidth:0] PtrOne = {{IdxWidth{1'b0}}, 1'b1};

  typedef logic [PacketWidth-1:0] packet_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRead,
    StReturn
  } state_e;

  state_e  state_q, state_d;
  packet_t hold_q, hold_d;
  logic    ack_q;

  packet_t           fifo_mem [QUEUE_SIZE];
  logic [IdxWidth:0] wr_ptr_q, rd_ptr_q;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable at equal indices.
  assign fifo_full  = (wr_ptr_q[IdxWidth-1:0] == rd_ptr_q[IdxWidth-1:0]) &&
                      (wr_ptr_q[IdxWidth] != rd_ptr_q[IdxWidth]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  // Ack gating gives the producer one cycle to drop valid before it could be re-accepted.
  assign push = to_mem_packet_in[ValidPos] && !fifo_full && !ack_q;

  assign to_mem_packet_ack_out = ack_q;

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q[IdxWidth-1:0]] <= to_mem_packet_in;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_q    <= 1'b0;
      state_q  <= StIdle;
      hold_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      ack_q   <= push;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    hold_d              = hold_q;
    pop                 = 1'b0;
    mem_req_out         = 1'b0;
    mem_we_out          = 1'b0;
    mem_addr_out        = '0;
    mem_wdata_out       = '0;
    from_mem_packet_out = '0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_mem[rd_ptr_q[IdxWidth-1:0]];
          state_d = StIssue;
        end
      end
      StIssue: begin
        mem_req_out   = 1'b1;
        mem_we_out    = hold_q[PACKET_WRITE_POS];
        mem_addr_out  = hold_q[AddrPosLo +: AddrWidth];
        mem_wdata_out = hold_q[PACKET_DATA_POS_LO +: DATA_WIDTH];
        if (mem_ready_in) begin
          state_d = hold_q[PACKET_WRITE_POS] ? StIdle : StWaitRead;
        end
      end
      StWaitRead: begin
        if (mem_rvalid_in) begin
          hold_d[PACKET_DATA_POS_LO +: DATA_WIDTH] = mem_rdata_in;
          hold_d[ValidPos]                         = 1'b1;
          state_d                                  = StReturn;
        end
      end
      StReturn: begin
        from_mem_packet_out = hold_q;
        if (from_mem_packet_ack_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_unified_cache_mem_bridge.sv
// Directed bench for unified_cache_mem_bridge: a table of single transactions plus hand-written
// sequences for FIFO full, return backpressure, mid-transaction reset and pointer wrap-around.

module tb_unified_cache_mem_bridge;

  localparam int PW = 66;

  logic          clk = 1'b0;
  logic          reset_in;
  logic [PW-1:0] to_mem_packet_in;
  logic          to_mem_packet_ack_out;
  logic [PW-1:0] from_mem_packet_out;
  logic          from_mem_packet_ack_in;
  logic          mem_req_out;
  logic          mem_ready_in;
  logic          mem_we_out;
  logic [31:0]   mem_addr_out;
  logic [31:0]   mem_wdata_out;
  logic          mem_rvalid_in;
  logic [31:0]   mem_rdata_in;

  int nchecks = 0;
  int nerrors = 0;

  unified_cache_mem_bridge dut (
    .clk_in                 (clk),
    .reset_in               (reset_in),
    .to_mem_packet_in       (to_mem_packet_in),
    .to_mem_packet_ack_out  (to_mem_packet_ack_out),
    .from_mem_packet_out    (from_mem_packet_out),
    .from_mem_packet_ack_in (from_mem_packet_ack_in),
    .mem_req_out            (mem_req_out),
    .mem_ready_in           (mem_ready_in),
    .mem_we_out             (mem_we_out),
    .mem_addr_out           (mem_addr_out),
    .mem_wdata_out          (mem_wdata_out),
    .mem_rvalid_in          (mem_rvalid_in),
    .mem_rdata_in           (mem_rdata_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_dly;
    int          rv_dly;
    int          ack_dly;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ret;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  vec_t vecs[6];
  txn_t exp_q[$];

  function automatic logic [PW-1:0] mk_pkt(input logic we, input logic [31:0] addr,
                                           input logic [31:0] data);
    logic [PW-1:0] p;
    p        = '0;
    p[0]     = 1'b1;
    p[1]     = we;
    p[33:2]  = addr;
    p[65:34] = data;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [PW-1:0] p, input int bound, output bit acked);
    acked = 1'b0;
    to_mem_packet_in = p;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (to_mem_packet_ack_out) begin
        acked = 1'b1;
        break;
      end
    end
    to_mem_packet_in = '0;
  endtask

  task automatic fire();
    mem_ready_in = 1'b1;
    tick();
    mem_ready_in = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit            ok;
    bit            bad;
    logic [PW-1:0] exp_pkt;
    push(mk_pkt(v.we, v.addr, v.wdata), 10, ok);
    chk("vec_acked", ok, 1'b1);
    tick();
    chk("ack_one_cycle", to_mem_packet_ack_out, 1'b0);
    chk("issue_latency", mem_req_out, 1'b1);
    chk("issue_we", mem_we_out, v.exp_we);
    chk("issue_addr", mem_addr_out, v.exp_addr);
    chk("issue_wdata", mem_wdata_out, v.exp_wdata);
    for (int k = 0; k < v.ready_dly; k++) begin
      tick();
      chk("issue_hold_stable", {mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out},
          {1'b1, v.exp_we, v.exp_addr, v.exp_wdata});
    end
    fire();
    chk("req_drop_after_fire", mem_req_out, 1'b0);
    if (v.we) begin
      // A stray read return while idle must not fabricate a fill.
      bad           = 1'b0;
      mem_rvalid_in = 1'b1;
      mem_rdata_in  = 32'hFFFF_FFFF;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (from_mem_packet_out[0] !== 1'b0) bad = 1'b1;
      end
      mem_rvalid_in = 1'b0;
      mem_rdata_in  = '0;
      chk("write_no_return", bad, 1'b0);
    end else begin
      exp_pkt = mk_pkt(1'b0, v.exp_addr, v.exp_ret);
      from_mem_packet_ack_in = 1'b1;  // ignored while waiting on memory
      for (int k = 0; k < v.rv_dly; k++) tick();
      from_mem_packet_ack_in = 1'b0;
      chk("wait_no_return", from_mem_packet_out, '0);
      mem_rvalid_in = 1'b1;
      mem_rdata_in  = v.rdata;
      tick();
      mem_rvalid_in = 1'b0;
      mem_rdata_in  = '0;
      chk("ret_pkt", from_mem_packet_out, exp_pkt);
      for (int k = 0; k < v.ack_dly; k++) begin
        tick();
        chk("ret_stable", {mem_req_out, from_mem_packet_out}, {1'b0, exp_pkt});
      end
      from_mem_packet_ack_in = 1'b1;
      tick();
      from_mem_packet_ack_in = 1'b0;
      chk("ret_clear", {mem_req_out, from_mem_packet_out}, '0);
    end
  endtask

  initial begin
    bit            ok;
    bit            bad;
    int            acks;
    logic [31:0]   issued[$];
    logic [PW-1:0] exp_pkt;

    vecs[0] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 0, 2, 0,
                1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0080, 32'h1234_5678, 32'h0000_0000, 0, 0, 0,
                1'b1, 32'h0000_0080, 32'h1234_5678, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'h0000_01FC, 32'h0000_0000, 32'hCAFE_F00D, 3, 0, 10,
                1'b0, 32'h0000_01FC, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0, 0,
                1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 5, 2,
                1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h7FFF_0000, 32'hAAAA_AAAA, 32'h1357_9BDF, 0, 1, 1,
                1'b0, 32'h7FFF_0000, 32'hAAAA_AAAA, 32'h1357_9BDF};

    reset_in               = 1'b1;
    to_mem_packet_in       = '0;
    from_mem_packet_ack_in = 1'b0;
    mem_ready_in           = 1'b0;
    mem_rvalid_in          = 1'b0;
    mem_rdata_in           = '0;
    repeat (3) tick();
    chk("reset_outputs", {to_mem_packet_ack_out, mem_req_out, mem_we_out, mem_addr_out,
                          mem_wdata_out, from_mem_packet_out}, '0);
    reset_in = 1'b0;
    tick();
    chk("idle_after_reset", {mem_req_out, from_mem_packet_out}, '0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // FIFO full: four queued plus one held, sixth must wait.
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      push(mk_pkt(1'b1, 32'h100 + 32'(i * 4), 32'(i)), 6, ok);
      acks += int'(ok);
    end
    chk("full_ack_count", acks, 5);
    bad = 1'b0;
    to_mem_packet_in = mk_pkt(1'b1, 32'h114, 32'd5);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (to_mem_packet_ack_out !== 1'b0) bad = 1'b1;
    end
    chk("full_no_ack", bad, 1'b0);
    issued.delete();
    fork
      begin
        bit got = 1'b0;
        for (int k = 0; k < 20; k++) begin
          tick();
          if (to_mem_packet_ack_out) begin
            got = 1'b1;
            break;
          end
        end
        to_mem_packet_in = '0;
        chk("full_sixth_acked", got, 1'b1);
      end
      begin
        mem_ready_in = 1'b1;
        for (int k = 0; k < 40 && issued.size() < 6; k++) begin
          if (mem_req_out) issued.push_back(mem_addr_out);
          tick();
        end
        mem_ready_in = 1'b0;
      end
    join
    chk("full_issue_count", issued.size(), 6);
    for (int i = 0; i < 6 && i < issued.size(); i++)
      chk("full_issue_order", issued[i], 32'h100 + 32'(i * 4));
    repeat (2) tick();

    // Backpressure in RETURN while another request is accepted behind it.
    exp_pkt = mk_pkt(1'b0, 32'h300, 32'h600D_F00D);
    push(mk_pkt(1'b0, 32'h300, 32'h0), 10, ok);
    tick();
    fire();
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'h600D_F00D;
    tick();
    mem_rvalid_in = 1'b0;
    push(mk_pkt(1'b1, 32'h304, 32'h77), 5, ok);
    chk("accept_in_return", ok, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_stable", {mem_req_out, from_mem_packet_out}, {1'b0, exp_pkt});
    end
    from_mem_packet_ack_in = 1'b1;
    tick();
    from_mem_packet_ack_in = 1'b0;
    chk("bp_clear", from_mem_packet_out, '0);
    tick();
    chk("bp_next_issue", {mem_req_out, mem_we_out, mem_addr_out}, {1'b1, 1'b1, 32'h304});
    fire();

    // Reset while waiting for read data, with a second request queued.
    push(mk_pkt(1'b0, 32'h500, 32'h0), 10, ok);
    tick();
    fire();
    push(mk_pkt(1'b0, 32'h504, 32'h0), 10, ok);
    chk("rst_pre_ack", to_mem_packet_ack_out, 1'b1);
    #2;
    reset_in = 1'b1;
    #1;
    chk("rst_async_outputs", {to_mem_packet_ack_out, mem_req_out, mem_we_out, mem_addr_out,
                              mem_wdata_out, from_mem_packet_out}, '0);
    tick();
    reset_in      = 1'b0;
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'hBAD0_BAD0;
    tick();
    mem_rvalid_in = 1'b0;
    mem_rdata_in  = '0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (mem_req_out !== 1'b0 || from_mem_packet_out !== '0) bad = 1'b1;
    end
    chk("rst_abandon", bad, 1'b0);

    // Wrap-around: 20 mixed requests with random handshake delays.
    exp_q.delete();
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          txn_t t;
          bit   acc;
          t.we   = (n % 3 == 0);
          t.addr = 32'h1000 + 32'(n * 4);
          t.data = 32'h111 * 32'(n);
          repeat ($urandom_range(0, 3)) tick();
          push(mk_pkt(t.we, t.addr, t.data), 300, acc);
          if (acc) exp_q.push_back(t);
          else chk("wrap_push_acked", acc, 1'b1);
        end
      end
      begin
        for (int n = 0; n < 20; n++) begin
          bit   found = 1'b0;
          txn_t e;
          for (int k = 0; k < 400; k++) begin
            if (mem_req_out) begin
              found = 1'b1;
              break;
            end
            tick();
          end
          if (!found) begin
            chk("wrap_req_seen", found, 1'b1);
            break;
          end
          repeat ($urandom_range(0, 3)) tick();
          if (exp_q.size() == 0) begin
            chk("wrap_unexpected_issue", mem_addr_out, 32'hFFFF_FFFF);
            fire();
            continue;
          end
          e = exp_q.pop_front();
          chk("wrap_issue_order", {mem_we_out, mem_addr_out, mem_wdata_out},
              {e.we, e.addr, e.data});
          fire();
          if (!e.we) begin
            repeat ($urandom_range(0, 3)) tick();
            mem_rvalid_in = 1'b1;
            mem_rdata_in  = e.addr ^ 32'h5A5A_5A5A;
            tick();
            mem_rvalid_in = 1'b0;
            chk("wrap_ret", from_mem_packet_out,
                mk_pkt(1'b0, e.addr, e.addr ^ 32'h5A5A_5A5A));
            repeat ($urandom_range(0, 3)) tick();
            from_mem_packet_ack_in = 1'b1;
            tick();
            from_mem_packet_ack_in = 1'b0;
          end
        end
      end
    join
    chk("wrap_none_left", exp_q.size(), 0);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_req_out !== 1'b0) bad = 1'b1;
    end
    chk("wrap_no_duplicate", bad, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/unified_cache_mem_bridge.md
UNIFIED_CACHE_MEM_BRIDGE -- requirements
Module: unified_cache_mem_bridge

Interface
REQ-001 The block SHALL take parameter UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, default `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS; this is the packet width on both packet ports.
REQ-002 The block SHALL take parameter QUEUE_SIZE, default 4; this is the request FIFO depth, a power of 2 and at least 2.
REQ-003 The block SHALL take parameter DATA_WIDTH, default 32; this is the block data width (BLOCK_SIZE_IN_BYTES*8).
REQ-004 The block SHALL take parameter PACKET_WRITE_POS, default `UNIFIED_CACHE_PACKET_IS_WRITE_POS; this is the packet bit marking a writeback (1) versus a miss fill (0).
REQ-005 The block SHALL take parameter PACKET_DATA_POS_LO, default `UNIFIED_CACHE_PACKET_DATA_POS_LO; this is the LSB of the DATA_WIDTH data field.
REQ-006 clk_in, input, 1 bit: the single clock; every flop is rising-edge.
REQ-007 reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-008 to_mem_packet_in, input, UNIFIED_CACHE_PACKET_WIDTH_IN_BITS bits: request from the cache arbiter; it is valid when bit `UNIFIED_CACHE_PACKET_VALID_POS is set.
REQ-009 to_mem_packet_ack_out, output, 1 bit: one-cycle pulse meaning the packet is accepted.
REQ-010 from_mem_packet_out, output, UNIFIED_CACHE_PACKET_WIDTH_IN_BITS bits: fill packet returned to the cache.
REQ-011 from_mem_packet_ack_in, input, 1 bit: the cache has consumed the fill packet.
REQ-012 mem_req_out, input mem_ready_in, mem_we_out, mem_addr_out: memory request handshake, write enable, and `CPU_ADDR_LEN_IN_BITS-bit address.
REQ-013 mem_wdata_out, output, DATA_WIDTH bits; mem_rvalid_in, input, 1 bit; mem_rdata_in, input, DATA_WIDTH bits: memory write data and the read-data return.

Function
REQ-014 Acceptance SHALL happen when the input is valid, the FIFO is not full, and to_mem_packet_ack_out is 0. Acceptance pushes the whole packet into the FIFO and sets a registered to_mem_packet_ack_out=1 for exactly the next cycle. The producer drops valid after it sees the ack.
REQ-015 The FIFO SHALL hold up to QUEUE_SIZE packets in order. Its read/write pointers have one extra wrap bit: full when the indices are equal and the wrap bits differ, empty when pointer and wrap bits are all equal. A valid input while full SHALL get no ack and SHALL not be dropped.
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT_READ and RETURN.
  - IDLE to ISSUE when the FIFO is not empty; the head packet is latched into a holding register and popped in the same cycle.
REQ-017 ISSUE SHALL drive the memory request from the holding register.
  - Outputs: mem_req_out=1, mem_addr_out=packet address field, mem_we_out=write bit, mem_wdata_out=data field.
  - The transfer fires on a cycle with mem_req_out and mem_ready_in both 1.
  - On fire: a write goes to IDLE and a read goes to WAIT_READ.
  - Without mem_ready_in, all outputs stay stable.
REQ-018 WAIT_READ SHALL hold mem_req_out=0. On mem_rvalid_in=1 it captures mem_rdata_in into the data field of the held packet, sets the valid bit, and moves to RETURN.
REQ-019 RETURN SHALL drive from_mem_packet_out with the held packet, unchanged, until a cycle in which from_mem_packet_ack_in=1; the next cycle is IDLE with from_mem_packet_out=0.
REQ-020 Outside RETURN, from_mem_packet_out SHALL be all zeros (valid bit 0). Outside ISSUE, mem_req_out, mem_we_out, mem_addr_out and mem_wdata_out SHALL be 0.
REQ-021 Only one memory transaction SHALL be outstanding at a time. FIFO accepts continue in every state.
REQ-022 A simultaneous push and pop SHALL both take effect, including when the FIFO is full, as long as acceptance rules allow the push. The occupancy count stays consistent across pointer wrap-around.
REQ-023 An mem_rvalid_in seen outside WAIT_READ SHALL be ignored. An from_mem_packet_ack_in seen outside RETURN SHALL be ignored.
REQ-024 Minimum write latency SHALL be accept at cycle 0, ack at 1, ISSUE at 2 (pop happens on the 1→2 edge), fire at 2 if ready, IDLE at 3.

Reset
REQ-025 reset_in=1 SHALL immediately force all of these: state IDLE, FIFO pointers 0 (empty), holding register 0, to_mem_packet_ack_out=0, from_mem_packet_out=0, and all mem_* outputs 0.
REQ-026 A reset in the middle of a transaction SHALL abandon that transaction and discard the FIFO contents. After release, a late mem_rvalid_in SHALL be ignored.

Verification
REQ-027 Single read:
  - Stimulus: valid read at addr 0x40; mem_ready_in=1; mem_rvalid_in 3 cycles after fire with rdata 0xDEADBEEF; cache ack at first RETURN cycle.
  - Required: a single ack pulse; mem_req_out=1, we=0, addr 0x40; returned packet has data 0xDEADBEEF and valid=1; FSM back in IDLE one cycle after the cache ack.
REQ-028 Write:
  - Stimulus: writeback to addr 0x80 with data 0x12345678.
  - Required: mem_we_out=1 with wdata 0x12345678; from_mem_packet_out never valid.
REQ-029 Full FIFO:
  - Stimulus: mem_ready_in=0; push 6 back-to-back requests.
  - Required: 4 are in the FIFO and 1 is in the holding register (5 acks); the 6th waits unacked; once ready, all 6 issue in order.
REQ-030 Backpressure:
  - Stimulus: hold from_mem_packet_ack_in=0 for 10 cycles during RETURN.
  - Required: the packet is stable all 10 cycles and no new mem_req_out is issued.
REQ-031 Reset during WAIT_READ:
  - Stimulus: assert reset_in while in WAIT_READ, then drive mem_rvalid_in after release.
  - Required: every output is 0, the FIFO is empty, and no return packet is produced.
REQ-032 Wrap-around:
  - Stimulus: 20 mixed requests with random ready/rvalid/ack delays.
  - Required: issue order equals accept order; no request is lost or duplicated.
